// File: rtl/gemm32_operand_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : gemm32_operand_loader_if
// Description : Bundle of signals between the GEMM32 operand loader and its
//               surroundings: the byte-serial operand stream, the flattened
//               lane buses toward the dot-product, the returned sum, and the
//               result stream with status.
// Revision    : 1.0 - initial release
// ============================================================================
interface gemm32_operand_loader_if #(
  parameter int N_LANES = 32,
  parameter int SUM_W   = 18
);
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_data;
  logic [7:0]           in_kernel;
  logic                 in_last;
  logic [8*N_LANES-1:0] data_bus;
  logic [8*N_LANES-1:0] kernel_bus;
  logic [SUM_W-1:0]     dp_sum;
  logic                 res_valid;
  logic                 res_ready;
  logic [SUM_W-1:0]     res_data;
  logic                 busy;
  logic [15:0]          vec_count;

  // Producer / dot-product / result-consumer side.
  modport master (
    output in_valid, in_data, in_kernel, in_last, dp_sum, res_ready,
    input  in_ready, data_bus, kernel_bus, res_valid, res_data, busy, vec_count
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data, in_kernel, in_last, dp_sum, res_ready,
    output in_ready, data_bus, kernel_bus, res_valid, res_data, busy, vec_count
  );
endinterface
`default_nettype wire

// File: rtl/gemm32_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : gemm32_operand_loader
// Description : Collects byte-serial (data, kernel) pairs into the 32-lane
//               parallel operand buses of the GEMM32 dot-product, holds them
//               while the sum settles, captures the sum and hands it out on
//               a valid/ready result stream.
// Revision    : 1.0 - initial release
// ============================================================================
module gemm32_operand_loader #(
  parameter int N_LANES    = 32,
  parameter int DP_LATENCY = 2,
  parameter int SUM_W      = 18
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  gemm32_operand_loader_if.slave    io
);

  localparam int             IDX_W     = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(N_LANES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam int             CNT_W     = 5;
  // One extra count covers the cycle in which the new buses first reach the
  // dot-product; res_valid then rises DP_LATENCY+1 edges after the last pair.
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(DP_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e               state_q;
  logic [IDX_W-1:0]     lane_idx_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [8*N_LANES-1:0] data_q;
  logic [8*N_LANES-1:0] kernel_q;
  logic [SUM_W-1:0]     res_data_q;
  logic                 res_valid_q;
  logic                 in_ready_q;
  logic                 busy_q;
  logic [15:0]          vec_count_q;

  // Loader FSM: fill lanes, wait for the sum, present the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      lane_idx_q  <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      kernel_q    <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      vec_count_q <= '0;
    end else begin
      unique case (state_q)
        S_FILL: begin
          if (io.in_valid && in_ready_q) begin
            data_q[{lane_idx_q, 3'b000} +: 8]   <= io.in_data;
            kernel_q[{lane_idx_q, 3'b000} +: 8] <= io.in_kernel;
            lane_idx_q <= lane_idx_q + IDX_ONE;
            if (io.in_last || (lane_idx_q == LAST_LANE)) begin
              state_q    <= S_WAIT;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              cnt_q      <= CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == CNT_ONE) begin
            res_data_q  <= io.dp_sum;
            res_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_OUT: begin
          if (io.res_ready) begin
            vec_count_q <= vec_count_q + 16'd1;
            data_q      <= '0;
            kernel_q    <= '0;
            lane_idx_q  <= '0;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_FILL;
          end
        end
        default: begin
          state_q     <= S_FILL;
          lane_idx_q  <= '0;
          res_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign io.in_ready   = in_ready_q;
  assign io.data_bus   = data_q;
  assign io.kernel_bus = kernel_q;
  assign io.res_valid  = res_valid_q;
  assign io.res_data   = res_data_q;
  assign io.busy       = busy_q;
  assign io.vec_count  = vec_count_q;

endmodule
`default_nettype wire

// File: tb/tb_gemm32_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_gemm32_operand_loader
// Description : Self-checking bench for the GEMM32 operand loader with a
//               behavioural dot-product and a vector-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gemm32_operand_loader;

  localparam int N   = 32;
  localparam int LAT = 2;
  localparam int SW  = 18;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_vec  = 0;
  logic [SW-1:0] exp_sum;
  logic [7:0]    vd [N];
  logic [7:0]    vk [N];
  logic [SW-1:0] dp_acc;

  gemm32_operand_loader_if #(.N_LANES(N), .SUM_W(SW)) io ();

  gemm32_operand_loader #(.N_LANES(N), .DP_LATENCY(LAT), .SUM_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dot-product: unsigned sum of lane products, SUM_W wrap.
  always_comb begin
    dp_acc = '0;
    for (int l = 0; l < N; l++)
      dp_acc = dp_acc + SW'(16'(io.data_bus[8*l +: 8]) * 16'(io.kernel_bus[8*l +: 8]));
    io.dp_sum = dp_acc;
  end

  task automatic check_value(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The two streams must never be open at the same time.
  always @(negedge clk)
    if (!rst) check_value("ready_valid_excl", {255'd0, io.in_ready & io.res_valid}, 256'd0);

  // Send vd/vk[0..n-1] as one vector, check buses, latency, result and handshake.
  task automatic run_vector(input int n, input bit use_last, input bit gaps,
                            input int hold, input bit do_hs);
    int guard;
    int lat;
    logic [255:0] eb_d;
    logic [255:0] eb_k;
    eb_d    = '0;
    eb_k    = '0;
    exp_sum = '0;
    for (int i = 0; i < n; i++) begin
      eb_d[8*i +: 8] = vd[i];
      eb_k[8*i +: 8] = vk[i];
      exp_sum = exp_sum + SW'(16'(vd[i]) * 16'(vk[i]));
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        io.in_valid = 1'b0;
        @(negedge clk);
      end
      io.in_valid  = 1'b1;
      io.in_data   = vd[i];
      io.in_kernel = vk[i];
      io.in_last   = use_last && (i == n - 1);
      guard = 0;
      while (!io.in_ready && guard < 64) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 64) begin
        check_value("accept_timeout", 256'd1, 256'd0);
        io.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    io.in_valid = 1'b0;
    io.in_last  = 1'b0;
    check_value("in_ready_after_last", {255'd0, io.in_ready}, 256'd0);
    check_value("busy_in_wait", {255'd0, io.busy}, 256'd1);
    check_value("data_bus", io.data_bus, eb_d);
    check_value("kernel_bus", io.kernel_bus, eb_k);
    lat = 0;
    while (!io.res_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check_value("latency", 256'(lat), 256'(LAT + 1));
    check_value("res_data", {238'd0, io.res_data}, {238'd0, exp_sum});
    for (int h = 0; h < hold; h++) begin
      io.in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_value("hold_res_valid", {255'd0, io.res_valid}, 256'd1);
      check_value("hold_res_data", {238'd0, io.res_data}, {238'd0, exp_sum});
      check_value("hold_data_bus", io.data_bus, eb_d);
      check_value("hold_in_ready", {255'd0, io.in_ready}, 256'd0);
    end
    io.in_valid = 1'b0;
    if (!do_hs) return;
    io.res_ready = 1'b1;
    @(negedge clk);
    io.res_ready = 1'b0;
    exp_vec = (exp_vec + 1) & 16'hFFFF;
    check_value("post_hs_res_valid", {255'd0, io.res_valid}, 256'd0);
    check_value("post_hs_in_ready", {255'd0, io.in_ready}, 256'd1);
    check_value("post_hs_busy", {255'd0, io.busy}, 256'd0);
    check_value("vec_count", {240'd0, io.vec_count}, 256'(exp_vec));
    check_value("post_hs_data_bus", io.data_bus, 256'd0);
    check_value("post_hs_kernel_bus", io.kernel_bus, 256'd0);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      vd[i] = 8'($urandom_range(0, 255));
      vk[i] = 8'($urandom_range(0, 255));
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.in_kernel = '0;
    io.in_last   = 1'b0;
    io.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check_value("rst_in_ready", {255'd0, io.in_ready}, 256'd1);
    check_value("rst_res_valid", {255'd0, io.res_valid}, 256'd0);
    check_value("rst_busy", {255'd0, io.busy}, 256'd0);
    check_value("rst_vec_count", {240'd0, io.vec_count}, 256'd0);
    check_value("rst_res_data", {238'd0, io.res_data}, 256'd0);
    check_value("rst_data_bus", io.data_bus, 256'd0);

    // Full vector, no in_last, back-to-back pairs: sum 1056.
    for (int i = 0; i < N; i++) begin
      vd[i] = 8'(i + 1);
      vk[i] = 8'd2;
    end
    run_vector(N, 1'b0, 1'b0, 0, 1'b1);
    check_value("full_sum_1056", {238'd0, exp_sum}, 256'd1056);

    // Short vector of five (3,4) pairs: sum 60, unwritten lanes zero.
    for (int i = 0; i < 5; i++) begin
      vd[i] = 8'd3;
      vk[i] = 8'd4;
    end
    run_vector(5, 1'b1, 1'b0, 0, 1'b1);

    // Result held under back-pressure for 10 cycles.
    fill_random(12);
    run_vector(12, 1'b1, 1'b0, 10, 1'b1);

    // Reset mid-fill after 17 lanes, then a fresh 20-pair vector.
    fill_random(17);
    for (int i = 0; i < 17; i++) begin
      io.in_valid  = 1'b1;
      io.in_data   = vd[i];
      io.in_kernel = vk[i];
      @(negedge clk);
    end
    io.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    exp_vec = 0;
    check_value("midfill_rst_data_bus", io.data_bus, 256'd0);
    check_value("midfill_rst_vec_count", {240'd0, io.vec_count}, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_random(20);
    run_vector(20, 1'b1, 1'b0, 1, 1'b1);

    // Randomised vectors: lengths 1..32, gaps, back-pressure, redundant last.
    for (int v = 0; v < 25; v++) begin
      int n;
      n = $urandom_range(1, N);
      fill_random(n);
      run_vector(n, (n < N) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1,
                 $urandom_range(0, 3), 1'b1);
    end

    // Reset pulse while the result is pending.
    fill_random(7);
    run_vector(7, 1'b1, 1'b0, 2, 1'b0);
    rst = 1'b1;
    #1;
    exp_vec = 0;
    check_value("out_rst_res_valid", {255'd0, io.res_valid}, 256'd0);
    check_value("out_rst_vec_count", {240'd0, io.vec_count}, 256'd0);
    check_value("out_rst_busy", {255'd0, io.busy}, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_value("out_rst_in_ready", {255'd0, io.in_ready}, 256'd1);
    check_value("out_rst_res_data", {238'd0, io.res_data}, 256'd0);

    // Loader still works after the reset.
    fill_random(3);
    run_vector(3, 1'b1, 1'b0, 0, 1'b1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
